// File: rtl/pixel_render.sv
// Pixel generation stage: draws background, player and coin layers from the
// live timing counters, keeps sync pixel-aligned with RGB (2-cycle latency),
// and reports a per-frame tick plus a player/coin overlap pulse.
module pixel_render #(
  parameter int          HDISP        = 640,
  parameter int          VDISP        = 480,
  parameter int          PLAYER_SIZE  = 32,
  parameter int          COIN_SIZE    = 16,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] PLAYER_COLOR = 12'h0F0,
  parameter logic [11:0] COIN_COLOR   = 12'hFF0,
  parameter int          BLINK_BIT    = 5
) (
  input  logic        pixClk,
  input  logic        rst,
  input  logic [10:0] horiz_counter,
  input  logic [10:0] vert_counter,
  input  logic        video,
  input  logic        horiz_sync_pulse,
  input  logic        vert_sync_pulse,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  coin_x,
  input  logic [9:0]  coin_y,
  input  logic        coin_valid,
  input  logic        coin_blink,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick,
  output logic        collide
);
  localparam logic [10:0] PSZ  = 11'(PLAYER_SIZE);
  localparam logic [10:0] CSZ  = 11'(COIN_SIZE);
  localparam logic [10:0] HMAX = 11'(HDISP);
  localparam logic [10:0] VMAX = 11'(VDISP);

  // Shadow positions: only these are used for drawing, so input changes
  // mid-frame never tear the picture.
  logic [9:0]  px_q, px_d, py_q, py_d, cx_q, cx_d, cy_q, cy_d;
  logic        cv_q, cv_d;
  logic [5:0]  fcnt_q, fcnt_d;
  logic        ovl_q, ovl_d;
  logic        p_hit_q, p_hit_d, c_hit_q, c_hit_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        tick_q, tick_d, col_q, col_d;

  logic        latch, in_act;
  logic [10:0] px_e, py_e, cx_e, cy_e;

  // Next-state: frame latch, stage-1 hit tests, stage-2 colour/overlap
  always_comb begin
    latch  = (horiz_counter == 11'd0) && (vert_counter == VMAX);
    // 11-bit extension keeps x+SIZE from wrapping past 1023
    px_e   = {1'b0, px_q};
    py_e   = {1'b0, py_q};
    cx_e   = {1'b0, cx_q};
    cy_e   = {1'b0, cy_q};
    in_act = (horiz_counter < HMAX) && (vert_counter < VMAX);

    px_d   = px_q;
    py_d   = py_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    cv_d   = cv_q;
    fcnt_d = fcnt_q;
    if (latch) begin
      px_d   = player_x;
      py_d   = player_y;
      cx_d   = coin_x;
      cy_d   = coin_y;
      cv_d   = coin_valid;
      fcnt_d = fcnt_q + 6'd1;
    end

    // Stage 1: hit tests against the shadow positions
    p_hit_d = in_act &&
              (horiz_counter >= px_e) && (horiz_counter < px_e + PSZ) &&
              (vert_counter  >= py_e) && (vert_counter  < py_e + PSZ);
    c_hit_d = in_act && cv_q &&
              (horiz_counter >= cx_e) && (horiz_counter < cx_e + CSZ) &&
              (vert_counter  >= cy_e) && (vert_counter  < cy_e + CSZ) &&
              (!coin_blink || !fcnt_q[BLINK_BIT]);

    // Stage 2: video input lines up with the stage-1 hits of the same pixel
    if (!video)       rgb_d = 12'h000;
    else if (p_hit_q) rgb_d = PLAYER_COLOR;
    else if (c_hit_q) rgb_d = COIN_COLOR;
    else              rgb_d = BG_COLOR;

    hs_d   = horiz_sync_pulse;
    vs_d   = vert_sync_pulse;
    tick_d = latch;
    col_d  = latch && ovl_q;

    // Latch clear wins over a same-cycle overlap set
    ovl_d = ovl_q;
    if (latch)                             ovl_d = 1'b0;
    else if (video && p_hit_q && c_hit_q)  ovl_d = 1'b1;
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      px_q    <= '0;
      py_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cv_q    <= 1'b0;
      fcnt_q  <= '0;
      ovl_q   <= 1'b0;
      p_hit_q <= 1'b0;
      c_hit_q <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      tick_q  <= 1'b0;
      col_q   <= 1'b0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cv_q    <= cv_d;
      fcnt_q  <= fcnt_d;
      ovl_q   <= ovl_d;
      p_hit_q <= p_hit_d;
      c_hit_q <= c_hit_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      tick_q  <= tick_d;
      col_q   <= col_d;
    end
  end

  assign rgb        = rgb_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign frame_tick = tick_q;
  assign collide    = col_q;
endmodule

// File: tb/tb_pixel_render.sv
// Randomized bench for pixel_render with an in-bench frame/pixel model and
// hand-computed literal probes for the headline scenarios.
module tb_pixel_render;
  logic        pixClk = 1'b0;
  logic        rst;
  logic [10:0] horiz_counter, vert_counter;
  logic        video, horiz_sync_pulse, vert_sync_pulse;
  logic [9:0]  player_x, player_y, coin_x, coin_y;
  logic        coin_valid, coin_blink;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_tick, collide;

  pixel_render dut (
    .pixClk(pixClk), .rst(rst),
    .horiz_counter(horiz_counter), .vert_counter(vert_counter),
    .video(video), .horiz_sync_pulse(horiz_sync_pulse), .vert_sync_pulse(vert_sync_pulse),
    .player_x(player_x), .player_y(player_y), .coin_x(coin_x), .coin_y(coin_y),
    .coin_valid(coin_valid), .coin_blink(coin_blink),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_tick(frame_tick), .collide(collide)
  );

  always #5 pixClk = ~pixClk;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: what was latched, how many frames, whether overlap was seen,
  // and the hit results of the previous pixel still in flight.
  int s_px, s_py, s_cx, s_cy, fcnt;
  bit s_cv, ovl, pph, pch;
  int e_rgb;
  bit e_hs, e_vs, e_tick, e_col;
  int prev_h = 700, prev_v = 500;

  function automatic bit in_sq(int h, int v, int x, int y, int s);
    return (h >= x) && (h < x + s) && (v >= y) && (v < y + s);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    s_px = 0; s_py = 0; s_cx = 0; s_cy = 0; s_cv = 0;
    fcnt = 0; ovl = 0; pph = 0; pch = 0;
  endtask

  // One pixel clock: drive counters (and lagged video/sync), advance the
  // model, then compare every output after the edge.
  task automatic step(int h, int v);
    bit vid, hs, vs, lat;
    vid = (prev_h < 640) && (prev_v < 480);
    hs  = (prev_h >= 656) && (prev_h < 752);
    vs  = (prev_v >= 490) && (prev_v < 492);
    horiz_counter    = 11'(h);
    vert_counter     = 11'(v);
    video            = vid;
    horiz_sync_pulse = hs;
    vert_sync_pulse  = vs;
    lat = (h == 0) && (v == 480);

    e_rgb  = !vid ? 12'h000 : pph ? 12'h0F0 : pch ? 12'hFF0 : 12'h000;
    e_hs   = hs;
    e_vs   = vs;
    e_tick = lat;
    e_col  = lat && ovl;
    if (lat) ovl = 0;
    else if (vid && pph && pch) ovl = 1;
    pph = in_sq(h, v, s_px, s_py, 32);
    pch = s_cv && in_sq(h, v, s_cx, s_cy, 16) && (!coin_blink || fcnt < 32);
    if (lat) begin
      s_px = int'(player_x); s_py = int'(player_y);
      s_cx = int'(coin_x);   s_cy = int'(coin_y);
      s_cv = coin_valid;
      fcnt = (fcnt + 1) % 64;
    end
    prev_h = h;
    prev_v = v;

    @(posedge pixClk);
    @(negedge pixClk);
    chk("rgb", int'(rgb), e_rgb);
    chk("hsync_out", int'(hsync_out), int'(e_hs));
    chk("vsync_out", int'(vsync_out), int'(e_vs));
    chk("frame_tick", int'(frame_tick), int'(e_tick));
    chk("collide", int'(collide), int'(e_col));
  endtask

  // Show pixel (h,v) then a blanking filler; rgb then belongs to (h,v).
  task automatic probe(string nm, int h, int v, int exp);
    step(h, v);
    step(700, 500);
    chk(nm, int'(rgb), exp);
  endtask

  task automatic latch_frame();
    step(0, 480);
  endtask

  task automatic rnd_pix();
    int h, v, r;
    r = $urandom_range(0, 3);
    if (r == 0) begin
      h = s_px + $urandom_range(0, 40) - 4;
      v = s_py + $urandom_range(0, 40) - 4;
    end else if (r == 1) begin
      h = s_cx + $urandom_range(0, 24) - 4;
      v = s_cy + $urandom_range(0, 24) - 4;
    end else begin
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 524);
    end
    if (h < 0) h = 0;
    if (h > 799) h = 799;
    if (v < 0) v = 0;
    if (v > 524) v = 524;
    if (h == 0 && v == 480) h = 1;
    step(h, v);
  endtask

  task automatic rnd_positions();
    player_x   = 10'($urandom_range(0, 660));
    player_y   = 10'($urandom_range(0, 500));
    coin_x     = 10'($urandom_range(0, 1023));
    coin_y     = 10'($urandom_range(0, 500));
    coin_valid = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int vis;
    rst = 1'b1;
    horiz_counter = 11'd700; vert_counter = 11'd500;
    video = 0; horiz_sync_pulse = 0; vert_sync_pulse = 0;
    player_x = 0; player_y = 0; coin_x = 0; coin_y = 0;
    coin_valid = 0; coin_blink = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge pixClk);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hsync", int'(hsync_out), 0);
    chk("reset_vsync", int'(vsync_out), 0);
    chk("reset_tick", int'(frame_tick), 0);
    chk("reset_collide", int'(collide), 0);
    rst = 1'b0;

    // First tick lands exactly one cycle after (0,480)
    step(660, 479); step(700, 490);
    latch_frame();
    chk("first_tick", int'(frame_tick), 1);
    chk("first_collide", int'(collide), 0);

    // Player alone: edges of the square
    player_x = 10'd100; player_y = 10'd50; coin_valid = 0;
    latch_frame();
    probe("player_at_100_50", 100, 50, 12'h0F0);
    probe("right_of_player", 132, 50, 12'h000);
    probe("left_of_player", 99, 50, 12'h000);

    // Overlap: player wins priority, collide reported on next tick
    player_x = 10'd100; player_y = 10'd100;
    coin_x = 10'd110; coin_y = 10'd110; coin_valid = 1;
    latch_frame();
    probe("overlap_pixel_green", 115, 115, 12'h0F0);
    repeat (50) rnd_pix();
    coin_x = 10'd300; coin_y = 10'd300;
    latch_frame();
    chk("collide_after_overlap", int'(collide), 1);
    repeat (50) rnd_pix();
    latch_frame();
    chk("no_collide_after_move", int'(collide), 0);

    // Mid-frame position change must not tear
    player_x = 10'd100; player_y = 10'd200; coin_valid = 0;
    latch_frame();
    probe("pre_change", 100, 210, 12'h0F0);
    player_x = 10'd200;
    probe("post_change_old_x", 100, 220, 12'h0F0);
    probe("post_change_new_x_off", 200, 220, 12'h000);
    latch_frame();
    probe("next_frame_new_x", 200, 220, 12'h0F0);
    probe("next_frame_old_x_off", 100, 220, 12'h000);

    // Clipping at the right/bottom edges, no wrap to x=0
    player_x = 10'd300; player_y = 10'd10;
    coin_x = 10'd630; coin_y = 10'd470; coin_valid = 1;
    latch_frame();
    probe("coin_on_edge", 635, 475, 12'hFF0);
    probe("coin_no_wrap", 5, 475, 12'h000);
    probe("coin_below_active", 635, 481, 12'h000);
    coin_x = 10'd1020;
    latch_frame();
    probe("coin_x1020_no_wrap", 4, 475, 12'h000);

    // Blink: visible for 32 of 64 frames
    coin_x = 10'd200; coin_y = 10'd200; coin_blink = 1;
    vis = 0;
    for (int f = 0; f < 64; f++) begin
      latch_frame();
      repeat (10) rnd_pix();
      step(205, 205);
      step(700, 500);
      if (rgb == 12'hFF0) vis++;
    end
    chk("blink_visible_frames", vis, 32);
    coin_blink = 0;

    // Randomized frames, positions changing mid-frame
    for (int f = 0; f < 25; f++) begin
      rnd_positions();
      coin_blink = 1'($urandom_range(0, 1));
      latch_frame();
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 99) == 0) rnd_positions();
        rnd_pix();
      end
    end

    // Mid-frame reset at line 300 with an overlap pending
    player_x = 10'd100; player_y = 10'd290;
    coin_x = 10'd105; coin_y = 10'd295; coin_valid = 1; coin_blink = 0;
    latch_frame();
    step(110, 300); step(110, 300);
    chk("green_before_reset", int'(rgb), 12'h0F0);
    @(posedge pixClk);
    #2 rst = 1'b1;
    #1;
    chk("async_rgb", int'(rgb), 0);
    chk("async_hsync", int'(hsync_out), 0);
    chk("async_vsync", int'(vsync_out), 0);
    chk("async_tick", int'(frame_tick), 0);
    chk("async_collide", int'(collide), 0);
    model_reset();
    repeat (2) @(negedge pixClk);
    rst = 1'b0;
    repeat (60) rnd_pix();
    latch_frame();
    chk("tick_after_reset", int'(frame_tick), 1);
    chk("no_collide_partial_frame", int'(collide), 0);
    repeat (30) rnd_pix();
    latch_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
